// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_pkg
// Brief    : Shared state encoding and opcode constants for ram_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package ram_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    RDOUT = 2'd2
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ram_array.sv
`default_nettype none
// ============================================================================
// Module   : ram_array
// Brief    : WIDTH x DEPTH storage, one synchronous write port, registered
//            read port with enable. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module ram_array
  import ram_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Read register only loads on enable so it holds the last read word.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_ctrl
// Brief    : Single-port RAM controller with clear sweep, range check and
//            1-cycle read latency. Optional write acknowledge when the macro
//            RAM_CTRL_WRACK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ram_ctrl
  import ram_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inp,
  input  logic [AW-1:0]    addr,
  input  logic             op,
  input  logic             sel,
  input  logic             clr,
  output logic [WIDTH-1:0] outp,
  output logic             valid,
  output logic             ready,
  output logic             err
);

  localparam logic [AW:0]   c_depth = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] c_last  = AW'(DEPTH - 1);

  state_t           r_state;
  logic [AW-1:0]    r_cnt;
  logic             r_ready;
  logic             r_valid;
  logic             r_err;
  logic             r_from_arr;
  logic [WIDTH-1:0] r_hold;

  logic             w_accept;
  logic             w_in_range;
  logic             w_wr;
  logic             w_rd;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_rdata;

  assign w_accept   = sel && r_ready && !clr;
  assign w_in_range = ({1'b0, addr} < c_depth);
  assign w_wr       = w_accept && (op == OP_WRITE) && w_in_range;
  assign w_rd       = w_accept && (op == OP_READ) && w_in_range;

  // The sweep owns the write port whenever the FSM sits in CLEAR.
  assign w_we    = (r_state == CLEAR) || w_wr;
  assign w_waddr = (r_state == CLEAR) ? r_cnt : addr;
  assign w_wdata = (r_state == CLEAR) ? '0 : inp;

  ram_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .re    (w_rd),
    .raddr (addr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CLEAR;
      r_cnt      <= '0;
      r_ready    <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_from_arr <= 1'b0;
      r_hold     <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        CLEAR: begin
          if (clr) begin
            r_cnt <= '0;
          end else if (r_cnt == c_last) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        IDLE, RDOUT: begin
          if (clr) begin
            r_state <= CLEAR;
            r_ready <= 1'b0;
            r_cnt   <= '0;
          end else if (sel) begin
            r_err <= !w_in_range;
            if (op == OP_READ) begin
              r_state <= RDOUT;
              r_valid <= 1'b1;
              if (w_in_range) begin
                r_from_arr <= 1'b1;
              end else begin
                r_from_arr <= 1'b0;
                r_hold     <= '0;
              end
            end else begin
              r_state <= IDLE;
`ifdef RAM_CTRL_WRACK_EN
              if (w_in_range) begin
                r_valid    <= 1'b1;
                r_from_arr <= 1'b0;
                r_hold     <= inp;
              end
`endif
            end
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_ready <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Read data comes straight from the array register; other sources are held locally.
  assign outp  = r_from_arr ? w_rdata : r_hold;
  assign valid = r_valid;
  assign ready = r_ready;
  assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_ctrl
// Brief    : Self-checking bench for ram_ctrl with a per-cycle reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_ctrl;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] inp = '0;
  logic [2:0] addr = '0;
  logic       op = 1'b0, sel = 1'b0, clr = 1'b0;
  logic [7:0] outp;
  logic       valid, ready, err;

  logic [7:0] inp6 = '0;
  logic [2:0] addr6 = '0;
  logic       op6 = 1'b0, sel6 = 1'b0;
  logic [7:0] outp6;
  logic       valid6, ready6, err6;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  ram_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .inp(inp), .addr(addr), .op(op), .sel(sel), .clr(clr),
    .outp(outp), .valid(valid), .ready(ready), .err(err)
  );

  ram_ctrl #(.WIDTH(8), .DEPTH(6)) dut6 (
    .clk(clk), .rst(rst), .inp(inp6), .addr(addr6), .op(op6), .sel(sel6), .clr(1'b0),
    .outp(outp6), .valid(valid6), .ready(ready6), .err(err6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: cycles of sweep remaining, plain array, expected outputs.
  logic [7:0] m_mem [DEPTH];
  int         m_left = DEPTH;
  logic [7:0] e_outp = '0;
  logic       e_valid = 1'b0, e_err = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left  = DEPTH;
      e_valid = 1'b0;
      e_err   = 1'b0;
      e_outp  = '0;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else begin
      e_valid = 1'b0;
      e_err   = 1'b0;
      if (m_left > 0) begin
        if (clr) m_left = DEPTH;
        else     m_left = m_left - 1;
      end else if (clr) begin
        m_left = DEPTH;
        foreach (m_mem[i]) m_mem[i] = '0;
      end else if (sel) begin
        if (int'(addr) >= DEPTH) begin
          e_err = 1'b1;
          if (!op) begin
            e_valid = 1'b1;
            e_outp  = '0;
          end
        end else if (op) begin
          m_mem[addr] = inp;
`ifdef RAM_CTRL_WRACK_EN
          e_valid = 1'b1;
          e_outp  = inp;
`endif
        end else begin
          e_valid = 1'b1;
          e_outp  = m_mem[addr];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_ready", {63'd0, ready}, {63'd0, (m_left == 0)});
      chk("model_valid", {63'd0, valid}, {63'd0, e_valid});
      chk("model_err",   {63'd0, err},   {63'd0, e_err});
      chk("model_outp",  {56'd0, outp},  {56'd0, e_outp});
    end
  end

  task automatic cyc(input logic s, input logic o, input logic c,
                     input logic [2:0] a, input logic [7:0] d);
    sel = s; op = o; clr = c; addr = a; inp = d;
    @(posedge clk); #2;
    sel = 1'b0; clr = 1'b0; op = 1'b0;
  endtask

  task automatic cyc6(input logic s, input logic o, input logic [2:0] a, input logic [7:0] d);
    sel6 = s; op6 = o; addr6 = a; inp6 = d;
    @(posedge clk); #2;
    sel6 = 1'b0; op6 = 1'b0;
  endtask

  int n;

  initial begin
    #1 rst = 1'b1;
    #1 chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_valid", {63'd0, valid}, 64'd0);
    chk("rst_outp",  {56'd0, outp},  64'd0);
    rst = 1'b0;

    n = 0;
    while (!ready && n < 20) begin cyc(0, 0, 0, 3'd0, 8'd0); n++; end
    chk("init_sweep_len", n, 8);

    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 3'(i), 8'd0);
      chk("init_read_outp",  {56'd0, outp},  64'd0);
      chk("init_read_valid", {63'd0, valid}, 64'd1);
    end
    cyc(0, 0, 0, 3'd0, 8'd0);
    chk("idle_valid", {63'd0, valid}, 64'd0);

    cyc(1, 1, 0, 3'd1, 8'hAA);
`ifdef RAM_CTRL_WRACK_EN
    chk("wr_aa_valid", {63'd0, valid}, 64'd1);
`else
    chk("wr_aa_valid", {63'd0, valid}, 64'd0);
`endif
    cyc(1, 0, 0, 3'd1, 8'd0);
    chk("rd1_outp",  {56'd0, outp},  64'hAA);
    chk("rd1_valid", {63'd0, valid}, 64'd1);
    cyc(1, 0, 0, 3'd2, 8'd0);
    chk("rd2_outp",  {56'd0, outp},  64'h00);

    cyc(1, 0, 0, 3'd1, 8'd0);
    chk("b2b_0", {55'd0, valid, outp}, {55'd0, 1'b1, 8'hAA});
    cyc(1, 0, 0, 3'd2, 8'd0);
    chk("b2b_1", {55'd0, valid, outp}, {55'd0, 1'b1, 8'h00});
    cyc(1, 0, 0, 3'd1, 8'd0);
    chk("b2b_2", {55'd0, valid, outp}, {55'd0, 1'b1, 8'hAA});
    cyc(0, 0, 0, 3'd0, 8'd0);
    chk("hold_outp", {55'd0, valid, outp}, {55'd0, 1'b0, 8'hAA});

    cyc(1, 1, 0, 3'd4, 8'h3C);
`ifdef RAM_CTRL_WRACK_EN
    chk("wrack", {55'd0, valid, outp}, {55'd0, 1'b1, 8'h3C});
`else
    chk("wrack", {55'd0, valid, outp}, {55'd0, 1'b0, 8'hAA});
`endif

    // clr wins over a same-cycle read; writes attempted during the sweep are dropped
    cyc(1, 1, 0, 3'd2, 8'hAB);
    cyc(1, 0, 1, 3'd2, 8'd0);
    chk("clr_drop_valid", {63'd0, valid}, 64'd0);
    n = 0;
    while (!ready && n < 20) begin cyc(1, 1, 0, 3'd3, 8'h77); n++; end
    chk("clr_sweep_len", n, 8);
    cyc(1, 0, 0, 3'd2, 8'd0);
    chk("clr_rd2", {55'd0, valid, outp}, {55'd0, 1'b1, 8'h00});
    cyc(1, 0, 0, 3'd3, 8'd0);
    chk("clr_rd3", {55'd0, valid, outp}, {55'd0, 1'b1, 8'h00});

    cyc(0, 0, 1, 3'd0, 8'd0);
    repeat (3) cyc(0, 0, 0, 3'd0, 8'd0);
    cyc(0, 0, 1, 3'd0, 8'd0);
    n = 0;
    while (!ready && n < 20) begin cyc(0, 0, 0, 3'd0, 8'd0); n++; end
    chk("clr_restart_len", n, 8);

    cyc(1, 1, 0, 3'd5, 8'h5A);
    cyc(0, 0, 1, 3'd0, 8'd0);
    cyc(0, 0, 0, 3'd0, 8'd0);
    cyc(0, 0, 0, 3'd0, 8'd0);
    rst = 1'b1;
    @(posedge clk); #2;
    chk("midrst_ready", {63'd0, ready}, 64'd0);
    chk("midrst_outp",  {56'd0, outp},  64'd0);
    rst = 1'b0;
    n = 0;
    while (!ready && n < 20) begin cyc(0, 0, 0, 3'd0, 8'd0); n++; end
    chk("midrst_sweep_len", n, 8);
    cyc(1, 0, 0, 3'd5, 8'd0);
    chk("midrst_rd5", {55'd0, valid, outp}, {55'd0, 1'b1, 8'h00});

    chk("d6_ready", {63'd0, ready6}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      cyc6(1, 1, 3'(i), 8'(8'h10 + i));
      chk("d6_wr_err", {63'd0, err6}, 64'd0);
    end
    cyc6(1, 1, 3'd7, 8'h55);
    chk("d6_oor_wr", {62'd0, err6, valid6}, {62'd0, 1'b1, 1'b0});
    cyc6(1, 0, 3'd7, 8'd0);
    chk("d6_oor_rd", {54'd0, err6, valid6, outp6}, {54'd0, 1'b1, 1'b1, 8'h00});
    cyc6(1, 1, 3'd6, 8'h66);
    chk("d6_oor_wr6", {62'd0, err6, valid6}, {62'd0, 1'b1, 1'b0});
    cyc6(0, 0, 3'd0, 8'd0);
    chk("d6_idle", {54'd0, err6, valid6, outp6}, {54'd0, 1'b0, 1'b0, 8'h00});
    for (int i = 0; i < 6; i++) begin
      cyc6(1, 0, 3'(i), 8'd0);
      chk("d6_rd", {54'd0, err6, valid6, outp6}, {54'd0, 1'b0, 1'b1, 8'(8'h10 + i)});
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 8, number of words (2..1024; need not be a power of two).
REQ-003 SHALL have derived localparam AW = $clog2(DEPTH), the address width.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 inp  input  WIDTH  write data.
REQ-007 addr  input  AW  word address.
REQ-008 op  input  1  operation: 1 = write, 0 = read.
REQ-009 sel  input  1  request strobe; a request is accepted on a rising edge where sel=1 and ready=1.
REQ-010 clr  input  1  clear request: zero the whole array.
REQ-011 outp  output  WIDTH  registered read data.
REQ-012 valid  output  1  one-cycle pulse qualifying outp.
REQ-013 ready  output  1  controller can accept a request this cycle.
REQ-014 err  output  1  one-cycle pulse flagging a rejected out-of-range access.

Function
REQ-015 The FSM SHALL have exactly three states: CLEAR, IDLE and RDOUT.
REQ-016 ready SHALL be 1 only in IDLE and RDOUT (fully pipelined: back-to-back requests are accepted with no bubble).
REQ-017 An accepted write (op=1) with addr<DEPTH SHALL store inp at addr on that same edge.
REQ-018 An accepted read (op=0) with addr<DEPTH SHALL drive outp=mem[addr] with valid=1 in the following cycle (latency 1); the FSM is in RDOUT for that cycle.
REQ-019 An accepted access with addr>=DEPTH SHALL leave memory unchanged and pulse err=1 in the next cycle; for a read, outp SHALL also be 0 with valid=1.
REQ-020 outp SHALL hold its last read value while valid=0.
REQ-021 clr=1 in IDLE or RDOUT SHALL enter CLEAR on the next edge; clr has priority over a same-cycle sel, and that request is not accepted.
REQ-022 In CLEAR, a counter SHALL write 0 to addresses 0..DEPTH-1, one per cycle; ready=0 for exactly DEPTH cycles, then the FSM enters IDLE.
REQ-023 clr=1 while in CLEAR SHALL restart the counter at 0.
REQ-024 sel during CLEAR SHALL be ignored, with no side effects.
REQ-025 A read and write to the same address on consecutive cycles SHALL return the newly written data.

Reset
REQ-026 While rst=1: outp=0, valid=0, err=0, ready=0, clear counter=0, state=CLEAR.
REQ-027 After rst deasserts, the FSM SHALL perform a full clear sweep (REQ-022) before ready first asserts.
REQ-028 rst asserted mid-sweep or mid-read SHALL abort the operation; the sweep then restarts from address 0.

Configuration
REQ-029 Macro RAM_CTRL_WRACK_EN defined: an accepted in-range write SHALL pulse valid=1 in the next cycle with outp=the written data (write acknowledge).
REQ-030 Macro RAM_CTRL_WRACK_EN undefined: writes SHALL never assert valid and SHALL leave outp unchanged.

Structure
REQ-031 Package ram_pkg SHALL hold the state enum type (CLEAR, IDLE, RDOUT) and the named constants OP_READ=0 and OP_WRITE=1.
REQ-032 Storage SHALL be one sub-module, ram_array: WIDTH x DEPTH, one synchronous write port, registered read, no reset on contents.
REQ-033 The FSM, clear counter, range check and output registers SHALL reside in ram_ctrl.

Verification (WIDTH=8, DEPTH=8 unless stated)
REQ-034 Release rst -> ready=0 for 8 cycles, then 1; reading addresses 0..7 returns 0x00 each, with valid one cycle after each sel.
REQ-035 Write 0xAA@1, then read @1 on the next cycle -> outp=0xAA, valid=1 one cycle later; read @2 -> 0x00.
REQ-036 Back-to-back reads @1,@2,@1 on 3 consecutive cycles -> valid high for 3 cycles, outp = 0xAA, 0x00, 0xAA.
REQ-037 DEPTH=6: write 0x55@7, then read @7 -> err pulses for each access, read returns outp=0x00 with valid=1, and mem[0..5] is unchanged.
REQ-038 Write 0xAB@2, then clr with a same-cycle sel read -> read dropped, ready=0 for 8 cycles, then read @2 -> 0x00; assert rst on sweep cycle 3 -> after release, a full 8-cycle sweep runs.
REQ-039 With RAM_CTRL_WRACK_EN: write 0x3C@4 -> valid=1, outp=0x3C next cycle; without the macro: valid stays 0 and outp keeps its previous value.
